// File: rtl/mem_bus_arbiter.sv
// ============================================================================
// mem_bus_arbiter
//   Round-robin two-port controller for a single-ported RAM with a shared
//   bidirectional data bus; each access runs SETUP/ACCESS/DONE.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_bus_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rwn,
  inout  wire  [DATA_W-1:0] mem_data
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              last;
  logic              owner;
  logic              cap_we;
  logic [DATA_W-1:0] cap_wdata;
  logic              drive;
  logic              grant_any;
  logic              grant_sel;

  // On a tie the requester that did not win last time gets the bus.
  always_comb begin
    grant_any = req0 | req1;
    grant_sel = (req0 & req1) ? ~last : req1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_any) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last      <= 1'b1;
      owner     <= 1'b0;
      cap_we    <= 1'b0;
      cap_wdata <= '0;
      mem_addr  <= '0;
      mem_rwn   <= 1'b1;
      drive     <= 1'b0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      busy      <= 1'b0;
      rdata     <= '0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      busy <= (state_nxt != IDLE);
      case (state)
        IDLE: begin
          if (grant_any) begin
            last      <= grant_sel;
            owner     <= grant_sel;
            cap_we    <= grant_sel ? we1 : we0;
            mem_addr  <= grant_sel ? addr1 : addr0;
            cap_wdata <= grant_sel ? wdata1 : wdata0;
          end
        end
        SETUP: begin
          mem_rwn <= ~cap_we;
          drive   <= cap_we;
        end
        ACCESS: begin
          // Raising rwn while mem_addr is held keeps the write address stable.
          mem_rwn <= 1'b1;
          drive   <= 1'b0;
          if (!cap_we) rdata <= mem_data;
          ack0 <= ~owner;
          ack1 <= owner;
        end
        default: ;
      endcase
    end
  end

  assign mem_data = drive ? cap_wdata : {DATA_W{1'bz}};

endmodule

`default_nettype wire
